// File: rtl/ilv_pkg.sv
// Shared definitions for the interleaved sample-stream stages: channel count and
// a width-generic saturating adder.
package ilv_pkg;
  localparam int CHANNELS = 32;
  localparam int CH_W     = $clog2(CHANNELS);
  localparam int SAT_W    = 64;

  typedef struct packed {
    logic             ovf;
    logic [SAT_W-1:0] sum;
  } sat_res_t;

  // a and b arrive sign-extended to SAT_W; the result is clamped to the signed w-bit range.
  function automatic sat_res_t sat_add(input logic signed [SAT_W-1:0] a,
                                       input logic signed [SAT_W-1:0] b,
                                       input int unsigned w);
    localparam logic signed [SAT_W:0] ONE = {{SAT_W{1'b0}}, 1'b1};
    logic signed [SAT_W:0] s, mx, mn;
    sat_res_t r;
    s  = {a[SAT_W-1], a} + {b[SAT_W-1], b};
    mx = (ONE <<< (w - 1)) - ONE;
    mn = -mx - ONE;
    r.ovf = 1'b0;
    r.sum = s[SAT_W-1:0];
    if (s > mx) begin
      r.ovf = 1'b1;
      r.sum = mx[SAT_W-1:0];
    end else if (s < mn) begin
      r.ovf = 1'b1;
      r.sum = mn[SAT_W-1:0];
    end
    return r;
  endfunction
endpackage

// File: rtl/ilv_acc_rf.sv
// Per-channel accumulator storage: async read, sync write, no reset
// (frame 0 of every decimation window overwrites each entry).
module ilv_acc_rf #(
  parameter int DEPTH = 32,
  parameter int W     = 36
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [W-1:0]             wdata,
  output logic [W-1:0]             rdata
);
  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk)
    if (we) mem[addr] <= wdata;

  // read-before-write: same-cycle read sees the old entry
  assign rdata = mem[addr];
endmodule

// File: rtl/ilv_decim_accum.sv
// Interleaved integrate-and-dump decimator: one accumulator per channel, one
// tagged sum per channel every DECIM frames. Define ILV_SAT_EN for saturating sums.
module ilv_decim_accum #(
  parameter int CHANNELS = 32,
  parameter int DATA_W   = 32,
  parameter int DECIM    = 4,
  parameter int ACC_W    = 36
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        i_clr,
  input  logic                        srdyi,
  input  logic [DATA_W-1:0]           i_data,
  output logic                        srdyo,
  output logic [ACC_W-1:0]            o_data,
  output logic [$clog2(CHANNELS)-1:0] o_chan,
  output logic                        o_sof,
  output logic                        o_ovf
);
  import ilv_pkg::*;

  localparam int CW = $clog2(CHANNELS);
  localparam int FW = (DECIM > 1) ? $clog2(DECIM) : 1;

  logic [CW-1:0]    ch_cnt;
  logic [FW-1:0]    frm_cnt;
  logic             accept, ch_last, frm_first, frm_last, dump;
  logic [ACC_W-1:0] x, rd_data, sum;

  assign accept    = srdyi & ~i_clr;
  assign ch_last   = ch_cnt == CW'(CHANNELS - 1);
  assign frm_first = frm_cnt == '0;
  assign frm_last  = frm_cnt == FW'(DECIM - 1);
  assign dump      = accept & frm_last;
  assign x         = ACC_W'(signed'(i_data));

`ifdef ILV_SAT_EN
  logic [ACC_W-1:0] base;
  sat_res_t         res;
  logic             sum_ovf;

  assign base = frm_first ? '0 : rd_data;
  always_comb res = sat_add(SAT_W'(signed'(base)), SAT_W'(signed'(x)), ACC_W);
  assign sum     = res.sum[ACC_W-1:0];
  assign sum_ovf = res.ovf;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)                o_ovf <= 1'b0;
    else if (i_clr)            o_ovf <= 1'b0;
    else if (accept & sum_ovf) o_ovf <= 1'b1;
`else
  assign sum   = frm_first ? x : rd_data + x;
  assign o_ovf = 1'b0;
`endif

  ilv_acc_rf #(.DEPTH(CHANNELS), .W(ACC_W)) u_rf (
    .clk   (clk),
    .we    (accept),
    .addr  (ch_cnt),
    .wdata (sum),
    .rdata (rd_data)
  );

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ch_cnt  <= '0;
      frm_cnt <= '0;
    end else if (i_clr) begin
      ch_cnt  <= '0;
      frm_cnt <= '0;
    end else if (srdyi) begin
      ch_cnt <= ch_last ? '0 : ch_cnt + 1'b1;
      if (ch_last) frm_cnt <= frm_last ? '0 : frm_cnt + 1'b1;
    end

  // payload holds between pulses; only srdyo returns to 0
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      srdyo  <= 1'b0;
      o_data <= '0;
      o_chan <= '0;
      o_sof  <= 1'b0;
    end else begin
      srdyo <= dump;
      if (dump) begin
        o_data <= sum;
        o_chan <= ch_cnt;
        o_sof  <= ch_cnt == '0;
      end
    end
endmodule

// File: tb/tb_ilv_decim_accum.sv
// Bench for ilv_decim_accum: a 36-bit and a 32-bit accumulator instance share
// stimulus and are checked against a sample-count based reference model.
module tb_ilv_decim_accum;
  localparam int C  = 32;
  localparam int DW = 32;
  localparam int D  = 4;

  logic          clk = 1'b0, rst_n = 1'b0, i_clr = 1'b0, srdyi = 1'b0;
  logic [DW-1:0] i_data = '0;
  logic          srdyo_a, o_sof_a, o_ovf_a, srdyo_b, o_sof_b, o_ovf_b;
  logic [35:0]   o_data_a;
  logic [31:0]   o_data_b;
  logic [4:0]    o_chan_a, o_chan_b;

  always #5 clk = ~clk;

  ilv_decim_accum #(.CHANNELS(C), .DATA_W(DW), .DECIM(D), .ACC_W(36)) dut (
    .clk(clk), .rst_n(rst_n), .i_clr(i_clr), .srdyi(srdyi), .i_data(i_data),
    .srdyo(srdyo_a), .o_data(o_data_a), .o_chan(o_chan_a), .o_sof(o_sof_a), .o_ovf(o_ovf_a));

  ilv_decim_accum #(.CHANNELS(C), .DATA_W(DW), .DECIM(D), .ACC_W(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .i_clr(i_clr), .srdyi(srdyi), .i_data(i_data),
    .srdyo(srdyo_b), .o_data(o_data_b), .o_chan(o_chan_b), .o_sof(o_sof_b), .o_ovf(o_ovf_b));

  int     nrun = 0, nfail = 0, npulse = 0, nsof = 0;
  // reference model: n = samples accepted since the last realign, modulo one window
  int     n = 0;
  longint acc_a [C];
  longint acc_b [C];
  bit     ovf_a = 0, ovf_b = 0;

  function automatic longint fit(input longint s, input int w, output bit ov);
    longint mx, mn;
    mx = (64'sd1 <<< (w - 1)) - 64'sd1;
    mn = -mx - 64'sd1;
    ov = 1'b0;
`ifdef ILV_SAT_EN
    if (s > mx) begin ov = 1'b1; return mx; end
    if (s < mn) begin ov = 1'b1; return mn; end
    return s;
`else
    return (s <<< (64 - w)) >>> (64 - w);
`endif
  endfunction

  task automatic tick(input bit v, input logic [DW-1:0] d, input bit clr);
    bit dump = 1'b0, oa, ob;
    int c = 0, f;
    longint x, sa, sb;
    logic [35:0] ea = '0;
    logic [31:0] eb = '0;
    srdyi = v; i_data = d; i_clr = clr;
    @(posedge clk);
    if (clr) begin
      n = 0; ovf_a = 0; ovf_b = 0;
    end else if (v) begin
      c  = n % C;
      f  = n / C;
      x  = longint'(signed'(d));
      sa = (f == 0) ? x : acc_a[c] + x;
      sb = (f == 0) ? x : acc_b[c] + x;
      acc_a[c] = fit(sa, 36, oa);
      acc_b[c] = fit(sb, 32, ob);
      ovf_a |= oa;
      ovf_b |= ob;
      n = (n + 1) % (C * D);
      if (f == D - 1) begin
        dump = 1'b1;
        ea = 36'(acc_a[c]);
        eb = 32'(acc_b[c]);
      end
    end
    @(negedge clk);
    nrun++;
    if (srdyo_a !== dump || srdyo_b !== dump) begin
      nfail++; $display("FAIL srdyo: got %b/%b want %b (n=%0d)", srdyo_a, srdyo_b, dump, n);
    end
    if (dump) begin
      npulse++;
      if (o_sof_a) nsof++;
      nrun++;
      if (o_data_a !== ea || o_data_b !== eb) begin
        nfail++; $display("FAIL o_data ch%0d: got %h/%h want %h/%h", c, o_data_a, o_data_b, ea, eb);
      end
      nrun++;
      if (o_chan_a !== 5'(c) || o_chan_b !== 5'(c) || o_sof_a !== (c == 0) || o_sof_b !== (c == 0)) begin
        nfail++; $display("FAIL o_chan/o_sof: got %0d/%0d sof %b/%b want %0d sof %b",
                          o_chan_a, o_chan_b, o_sof_a, o_sof_b, c, c == 0);
      end
    end
    nrun++;
    if (o_ovf_a !== ovf_a || o_ovf_b !== ovf_b) begin
      nfail++; $display("FAIL o_ovf: got %b/%b want %b/%b", o_ovf_a, o_ovf_b, ovf_a, ovf_b);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    nrun++;
    if ({srdyo_a, o_data_a, o_chan_a, o_sof_a, o_ovf_a} !== '0 || {srdyo_b, o_ovf_b} !== '0) begin
      nfail++; $display("FAIL reset: got srdyo=%b data=%h chan=%0d sof=%b ovf=%b want all 0",
                        srdyo_a, o_data_a, o_chan_a, o_sof_a, o_ovf_a);
    end
    @(negedge clk);
    rst_n = 1'b1;
    n = 0; ovf_a = 0; ovf_b = 0;
  endtask

  task automatic test_ones();
    npulse = 0; nsof = 0;
    for (int i = 0; i < C * D; i++) begin
      tick(1'b1, 32'd1, 1'b0);
      if (i == C * (D - 1) - 1) begin
        nrun++;
        if (npulse != 0) begin nfail++; $display("FAIL ones_early: got %0d pulses want 0", npulse); end
      end
    end
    nrun++;
    if (npulse != C || nsof != 1) begin
      nfail++; $display("FAIL ones_count: got %0d pulses %0d sof want %0d/1", npulse, nsof, C);
    end
  endtask

  task automatic test_ramp_gaps();
    npulse = 0;
    for (int i = 0; i < C * D; i++) begin
      tick(1'b1, 32'(i % C), 1'b0);
      repeat ($urandom_range(0, 5)) tick(1'b0, $urandom, 1'b0);
    end
    nrun++;
    if (npulse != C) begin nfail++; $display("FAIL ramp_count: got %0d want %0d", npulse, C); end
  endtask

  task automatic test_clear();
    npulse = 0;
    for (int i = 0; i < 2 * C + 17; i++) tick(1'b1, $urandom, 1'b0);
    tick(1'b1, 32'hDEAD_BEEF, 1'b1);
    for (int i = 0; i < C * D; i++) begin
      tick(1'b1, 32'(i % C) + 32'd100, 1'b0);
      if (i == C * (D - 1) - 1) begin
        nrun++;
        if (npulse != 0) begin nfail++; $display("FAIL clear_early: got %0d pulses want 0", npulse); end
      end
    end
    nrun++;
    if (npulse != C) begin nfail++; $display("FAIL clear_count: got %0d want %0d", npulse, C); end
  endtask

  task automatic test_ovf();
    logic [31:0] want_b;
    logic        want_ovf;
`ifdef ILV_SAT_EN
    want_b = 32'h7FFF_FFFF; want_ovf = 1'b1;
`else
    want_b = 32'hFFFF_FFFC; want_ovf = 1'b0;
`endif
    tick(1'b0, '0, 1'b1);
    for (int i = 0; i < C * D; i++) begin
      tick(1'b1, (i % C == 0) ? 32'h7FFF_FFFF : 32'($urandom_range(0, 100)), 1'b0);
      if (i == C * (D - 1)) begin
        nrun++;
        if (o_data_b !== want_b || o_ovf_b !== want_ovf) begin
          nfail++; $display("FAIL ovf32: got %h ovf=%b want %h ovf=%b", o_data_b, o_ovf_b, want_b, want_ovf);
        end
        nrun++;
        if (o_data_a !== 36'h1_FFFF_FFFC || o_ovf_a !== 1'b0) begin
          nfail++; $display("FAIL ovf36: got %h ovf=%b want 1fffffffc ovf=0", o_data_a, o_ovf_a);
        end
      end
    end
  endtask

  task automatic test_negative();
    tick(1'b0, '0, 1'b1);
    for (int i = 0; i < C * D; i++) begin
      tick(1'b1, (i % C == 3) ? 32'hFFFF_FFFB : 32'($urandom_range(0, 1000)), 1'b0);
      if (i == C * (D - 1) + 3) begin
        nrun++;
        if (o_data_a !== 36'hF_FFFF_FFEC || o_data_b !== 32'hFFFF_FFEC || o_chan_a !== 5'd3 || o_ovf_a !== 1'b0) begin
          nfail++; $display("FAIL neg: got %h/%h chan=%0d ovf=%b want fffffffec/ffffffec chan=3 ovf=0",
                            o_data_a, o_data_b, o_chan_a, o_ovf_a);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    npulse = 0;
    for (int i = 0; i < C * (D - 1) + 5; i++) tick(1'b1, $urandom, 1'b0);
    #2 rst_n = 1'b0; srdyi = 1'b0;
    #1;
    nrun++;
    if (srdyo_a !== 1'b0 || srdyo_b !== 1'b0 || o_data_a !== '0) begin
      nfail++; $display("FAIL async_rst: got srdyo=%b/%b data=%h want 0", srdyo_a, srdyo_b, o_data_a);
    end
    #1 rst_n = 1'b1;
    n = 0; ovf_a = 0; ovf_b = 0; npulse = 0;
    for (int i = 0; i < C * D; i++) tick(1'b1, $urandom, 1'b0);
    nrun++;
    if (npulse != C) begin nfail++; $display("FAIL async_count: got %0d want %0d", npulse, C); end
  endtask

  task automatic test_random();
    tick(1'b0, '0, 1'b1);
    for (int i = 0; i < 2 * C * D; i++) begin
      tick(1'b1, $urandom, 1'b0);
      if ($urandom_range(0, 3) == 0) tick(1'b0, $urandom, 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_ones();
    test_ramp_gaps();
    test_clear();
    test_ovf();
    test_negative();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", nrun, nfail);
    $finish;
  end
endmodule
